change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Sequential change-return engine for the vending datapath; the dispensing counterpart of the credit adder/subtractor.
- Takes a 5-bit change amount, already computed as credit minus price, and breaks it into coins by repeated greedy subtraction.
- Emits one coin request per valid/ready handshake to the coin-ejector mechanism.
- Reports completion, remaining amount and coins issued.

Parameters:
- WIDTH, 5, width of amount and remaining datapath.
- VAL_HI, 10, value of high coin (coin_sel=2).
- VAL_MID, 5, value of mid coin (coin_sel=1).
- VAL_LO, 1, value of low coin (coin_sel=0). Must be 1 so that every amount terminates.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to dispense amount. Sampled only in IDLE.
- amount  input  WIDTH  change to return (0..31).
- abort  input  1  cancels an in-progress dispense.
- coin_ready  input  1  ejector accepts the presented coin this cycle.
- coin_valid  output  1  coin request presented.
- coin_sel  output  2  coin code: 0=LO, 1=MID, 2=HI. Value 3 is never driven.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when remaining reaches 0.
- remaining  output  WIDTH  amount still owed (registered).
- coin_count  output  WIDTH  coins handed over since the last accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0: coin_valid, coin_sel, busy, done, remaining, coin_count.
- FSM states: IDLE, SELECT, PRESENT, DONE.
- IDLE:
  - start=1 at an edge: remaining<=amount, coin_count<=0.
  - Next state is SELECT, or DONE if amount==0.
  - start=0: stay in IDLE; remaining and coin_count hold their last values.
- SELECT (exactly 1 cycle):
  - coin_sel<=2 if remaining>=VAL_HI, else 1 if remaining>=VAL_MID, else 0.
  - Next state is PRESENT.
  - coin_valid is 0 during SELECT.
- PRESENT:
  - coin_valid=1. coin_sel holds stable until the handshake.
  - Handshake is coin_valid & coin_ready at a rising edge. On handshake: remaining<=remaining-value(coin_sel), coin_count<=coin_count+1.
  - Next state is DONE if the new remaining==0, else SELECT.
  - No handshake: stay in PRESENT; all outputs hold.
- DONE (1 cycle): done=1, busy=1, then IDLE. done is never high for two consecutive cycles.
- Subtraction:
  - Performed at WIDTH bits.
  - Greedy selection guarantees value<=remaining, so no borrow ever occurs. The bench asserts this.
- Latency:
  - Handshake at the first opportunity costs 2 cycles per coin.
  - First coin_valid appears 2 edges after start is sampled.
  - done asserts the cycle after the final handshake edge.
- start while busy: ignored; amount is not re-sampled.
- abort:
  - Applies in SELECT or PRESENT. At the next edge the state goes to IDLE and coin_valid drops.
  - No done pulse.
  - remaining and coin_count hold their values at the abort. A handshake in the same cycle as abort is ignored: no decrement, no count.
  - abort in IDLE or DONE has no effect; DONE still completes.
- coin_ready while coin_valid=0: ignored.
- Reset mid-dispense: immediate return to IDLE with all outputs 0. The in-flight coin is dropped.

Test Plan:
- Reset then amount=18, start pulse, coin_ready tied 1 -> coin_sel sequence 2,1,0,0 with one handshake every 2 cycles. done pulses once 9 edges after start. remaining=0, coin_count=4.
- amount=0, start -> no coin_valid. done pulses the cycle after start, busy high for exactly 1 cycle, coin_count=0.
- amount=31, coin_ready low for 5 cycles on the first coin, then 1 -> coin_valid held and coin_sel=2 stable during the stall. Sequence 2,2,2,0, coin_count=4, no borrow.
- amount=17, abort asserted in PRESENT of the second coin together with coin_ready=1 -> IDLE next edge, no done, remaining=7, coin_count=1.
- amount=12, start pulsed again mid-dispense with amount=30 -> ignored. Sequence 2,0,0, done once, remaining=0.
- rst_n pulsed low asynchronously (between edges) during PRESENT of amount=25 -> all outputs 0 immediately. A following start with amount=6 dispenses 1,0 correctly.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: breaks a change amount into coins by greedy subtraction
// and hands them one at a time to the coin ejector over a valid/ready link.
module change_dispenser #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned VAL_HI  = 10,
    parameter int unsigned VAL_MID = 5,
    parameter int unsigned VAL_LO  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] amount,
    input  logic             abort,
    input  logic             coin_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining,
    output logic [WIDTH-1:0] coin_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SELECT  = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] coin_value_c;
    logic [WIDTH-1:0] remaining_next_c;

    // Value of the coin currently presented and the amount left after it is taken.
    always_comb begin
        coin_value_c = WIDTH'(VAL_LO);
        case (coin_sel)
            2'd2:    coin_value_c = WIDTH'(VAL_HI);
            2'd1:    coin_value_c = WIDTH'(VAL_MID);
            default: coin_value_c = WIDTH'(VAL_LO);
        endcase
        // Greedy choice keeps coin_value_c <= remaining, so this never borrows.
        remaining_next_c = remaining - coin_value_c;
    end

    // Dispense FSM with registered outputs; abort takes priority over a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            coin_valid <= 1'b0;
            coin_sel   <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
            coin_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        remaining  <= amount;
                        coin_count <= '0;
                        busy       <= 1'b1;
                        if (amount == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (remaining >= WIDTH'(VAL_HI)) begin
                            coin_sel <= 2'd2;
                        end else if (remaining >= WIDTH'(VAL_MID)) begin
                            coin_sel <= 2'd1;
                        end else begin
                            coin_sel <= 2'd0;
                        end
                        coin_valid <= 1'b1;
                        state      <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        coin_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (coin_ready) begin
                        remaining  <= remaining_next_c;
                        coin_count <= coin_count + WIDTH'(1);
                        coin_valid <= 1'b0;
                        if (remaining_next_c == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SELECT;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
